// File: rtl/asi_rw_arb_if.sv
// Request/grant bundle between the read/write requesters and the user-memory-port arbiter.
interface asi_rw_arb_if;
  logic       m_arff_rvalid;
  logic       m_rbusy;
  logic       m_rlast;
  logic       rgranted;
  logic       m_awff_rvalid;
  logic       m_wbusy;
  logic       m_wlast;
  logic       wgranted;
  logic [1:0] arb_owner;

  modport master (
    output m_arff_rvalid, m_rbusy, m_rlast, m_awff_rvalid, m_wbusy, m_wlast,
    input  rgranted, wgranted, arb_owner
  );

  modport slave (
    input  m_arff_rvalid, m_rbusy, m_rlast, m_awff_rvalid, m_wbusy, m_wlast,
    output rgranted, wgranted, arb_owner
  );
endinterface

// File: rtl/asi_rw_arb.sv
// Read/write arbiter for the shared user memory port. A grant is held for a whole burst;
// the policy (round-robin, read priority, write priority) only matters on a tie.
module asi_rw_arb #(
  parameter int unsigned ARB_MODE = 0
) (
  input logic         usr_clk,
  input logic         usr_reset_n,
  asi_rw_arb_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRGnt = 2'b01,
    StWGnt = 2'b10
  } state_e;

  localparam logic SideRead  = 1'b0;
  localparam logic SideWrite = 1'b1;

  state_e state_q;
  logic   last_served_q;

  // Next owner from the request pair; last_w is the side that most recently finished.
  // Any mode other than 1 or 2 falls back to round-robin.
  function automatic state_e pick(input logic rreq, input logic wreq, input logic last_w);
    state_e nxt;
    if (rreq && wreq) begin
      if (ARB_MODE == 1)      nxt = StRGnt;
      else if (ARB_MODE == 2) nxt = StWGnt;
      else                    nxt = (last_w == SideWrite) ? StRGnt : StWGnt;
    end else if (rreq) begin
      nxt = StRGnt;
    end else if (wreq) begin
      nxt = StWGnt;
    end else begin
      nxt = StIdle;
    end
    return nxt;
  endfunction

  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      state_q       <= StIdle;
      last_served_q <= SideWrite;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= pick(bus.m_arff_rvalid, bus.m_awff_rvalid, last_served_q);
        end
        // Activity on the non-granted side is ignored while a burst is owned.
        StRGnt: begin
          if (bus.m_rbusy && bus.m_rlast) begin
            last_served_q <= SideRead;
            state_q       <= pick(bus.m_arff_rvalid, bus.m_awff_rvalid, SideRead);
          end else if (!bus.m_rbusy && !bus.m_arff_rvalid) begin
            state_q <= StIdle;
          end
        end
        StWGnt: begin
          if (bus.m_wbusy && bus.m_wlast) begin
            last_served_q <= SideWrite;
            state_q       <= pick(bus.m_arff_rvalid, bus.m_awff_rvalid, SideWrite);
          end else if (!bus.m_wbusy && !bus.m_awff_rvalid) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode the state register only, so no input reaches them combinationally.
  assign bus.rgranted  = (state_q == StRGnt);
  assign bus.wgranted  = (state_q == StWGnt);
  assign bus.arb_owner = state_q;

endmodule
